// File: rtl/hack_rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// hack_rom_loader_pkg
// Shared definitions for the ROM-loader receive path of the Hack SoC:
//   - 23LC1024 opcodes used by the loader (write, enter-SQI)
//   - loader FSM state encoding
//   - synchronizer depth for the asynchronous loader pins
//   - width of the serial shift word handed to the QSPI shifter
// -----------------------------------------------------------------------------
package hack_rom_loader_pkg;

  localparam logic [7:0] SRAM_CMD_WRITE = 8'h02;
  localparam logic [7:0] SRAM_CMD_EQIO  = 8'h38;

  localparam int SYNC_STAGES = 2;

  // Largest frame sent: 8-bit opcode + 24-bit address + 16-bit data.
  localparam int SHIFT_W = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUAD_EN,
    ST_WAIT_SCK,
    ST_WRITE,
    ST_ACK_HI
  } rx_state_e;

  typedef enum logic {
    MODE_SPI = 1'b0,
    MODE_SQI = 1'b1
  } qspi_mode_e;

endpackage

// File: rtl/qspi_write_shifter.sv
// -----------------------------------------------------------------------------
// qspi_write_shifter
// Emits one write-only CS frame to a 23LC1024 in SPI (1 bit per clock on SIO0)
// or SQI (1 nibble per clock on SIO3..0) mode, MSB first.
// Frame timing, counted in clk cycles from the start pulse being accepted:
//   cycle 0          : CS low, SCK low, first unit on SIO (CS setup)
//   cycles 1..2N     : SCK low/high pairs, SIO updated only while SCK is low
//   cycle 2N+1       : SCK low, CS still low (CS hold), done pulses here
//   cycle 2N+2       : CS high
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          pulse, accepted only while no frame is active
//   mode_sqi       1 = SQI nibbles, 0 = SPI bits
//   bit_count      total bits to send from shift_word (MSB-aligned)
//   shift_word     frame contents, left-aligned
//   cs_n, sck, sio registered SRAM bus outputs
//   done           one-cycle pulse during the CS hold cycle
// -----------------------------------------------------------------------------
module qspi_write_shifter
  import hack_rom_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode_sqi,
  input  logic [5:0]         bit_count,
  input  logic [SHIFT_W-1:0] shift_word,
  output logic               cs_n,
  output logic               sck,
  output logic [3:0]         sio,
  output logic               done
);

  logic               active_q, active_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [6:0]         last_q, last_d;
  logic               sqi_q, sqi_d;
  logic [SHIFT_W-1:0] shreg_q, shreg_d;
  logic               cs_n_q, cs_n_d;
  logic               sck_q, sck_d;
  logic [3:0]         sio_q, sio_d;
  logic               done_q, done_d;
  logic [5:0]         units;

  // In SPI mode SIO2/SIO3 are WP#/HOLD#; keep them high so the SRAM never holds.
  function automatic logic [3:0] lead_unit(input logic sqi, input logic [SHIFT_W-1:0] w);
    return sqi ? w[SHIFT_W-1 -: 4] : {3'b110, w[SHIFT_W-1]};
  endfunction

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    sqi_d    = sqi_q;
    shreg_d  = shreg_q;
    cs_n_d   = cs_n_q;
    sck_d    = sck_q;
    sio_d    = sio_q;
    done_d   = 1'b0;
    units    = mode_sqi ? {2'b00, bit_count[5:2]} : bit_count;

    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        cnt_d    = '0;
        last_d   = {units, 1'b1};
        sqi_d    = mode_sqi;
        cs_n_d   = 1'b0;
        sck_d    = 1'b0;
        sio_d    = lead_unit(mode_sqi, shift_word);
        shreg_d  = mode_sqi ? (shift_word << 4) : (shift_word << 1);
      end
    end else if (cnt_q == last_q) begin
      active_d = 1'b0;
      cs_n_d   = 1'b1;
      sck_d    = 1'b0;
      sio_d    = '0;
    end else begin
      cnt_d = cnt_q + 7'd1;
      // Even cycles are SCK-high; odd cycles (incl. the hold cycle) are low.
      sck_d = ~cnt_d[0];
      // The first unit was presented during setup, so shifting starts at unit 1.
      if (cnt_d[0] && (cnt_d >= 7'd3) && (cnt_d != last_q)) begin
        sio_d   = lead_unit(sqi_q, shreg_q);
        shreg_d = sqi_q ? (shreg_q << 4) : (shreg_q << 1);
      end
      done_d = (cnt_d == last_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      last_q   <= '0;
      sqi_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      sio_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      sqi_q    <= sqi_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      sio_q    <= sio_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign cs_n = cs_n_q;
  assign sck  = sck_q;
  assign sio  = sio_q;
  assign done = done_q;

endmodule

// File: rtl/rom_loader_rx.sv
// -----------------------------------------------------------------------------
// rom_loader_rx
// Receives instruction words from the external ROM loader over a four-phase
// load/sck/ack handshake and writes each one into the 23LC1024 instruction
// SRAM. While a session is active it owns the SRAM bus and raises busy, which
// the SoC uses to hold the CPU in reset.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   rom_loader_load             session enable (asynchronous)
//   rom_loader_sck              word strobe (asynchronous), data valid while high
//   rom_loader_data             instruction word
//   rom_loader_ack              word committed to SRAM
//   busy                        session active
//   rom_cs_n, rom_sck           SRAM chip select / serial clock
//   rom_sio_oe, rom_sio0..3_o   SRAM SIO drive enable and data
//   words_loaded                words committed in the current/last session
// -----------------------------------------------------------------------------
module rom_loader_rx
  import hack_rom_loader_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int WORD_ADDR_WIDTH = 16,
  parameter int SRAM_ADDR_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rom_loader_load,
  input  logic                       rom_loader_sck,
  input  logic [DATA_WIDTH-1:0]      rom_loader_data,
  output logic                       rom_loader_ack,
  output logic                       busy,
  output logic                       rom_cs_n,
  output logic                       rom_sck,
  output logic                       rom_sio_oe,
  output logic                       rom_sio0_o,
  output logic                       rom_sio1_o,
  output logic                       rom_sio2_o,
  output logic                       rom_sio3_o,
  output logic [WORD_ADDR_WIDTH-1:0] words_loaded
);

  localparam int         FRAME_W    = 8 + SRAM_ADDR_WIDTH + DATA_WIDTH;
  localparam logic [5:0] WRITE_BITS = 6'(FRAME_W);
  localparam logic [5:0] EQIO_BITS  = 6'd8;

  logic [SYNC_STAGES-1:0]     load_sync_q, sck_sync_q;
  logic                       sck_prev_q;
  logic                       load_s, sck_s, sck_rise;

  rx_state_e                  state_q;
  logic                       ack_q, busy_q, start_q;
  logic [WORD_ADDR_WIDTH-1:0] word_count_q;
  qspi_mode_e                 mode_q;
  logic [5:0]                 bits_q;
  logic [SHIFT_W-1:0]         frame_q;

  logic                       sh_cs_n, sh_sck, sh_done;
  logic [3:0]                 sh_sio;

  // Opcode, byte address (word index * 2) and data, left-aligned in the shift word.
  function automatic logic [SHIFT_W-1:0] write_frame(input logic [WORD_ADDR_WIDTH-1:0] word_idx,
                                                     input logic [DATA_WIDTH-1:0]      data);
    logic [FRAME_W-1:0] f;
    f = {SRAM_CMD_WRITE, SRAM_ADDR_WIDTH'({word_idx, 1'b0}), data};
    return SHIFT_W'(f) << (SHIFT_W - FRAME_W);
  endfunction

  assign load_s   = load_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_sync_q <= '0;
      sck_sync_q  <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], rom_loader_load};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], rom_loader_sck};
      sck_prev_q  <= sck_s;
    end
  end

  // Loader FSM. Frame setup (mode/bits/frame) is plain data and not reset;
  // it only matters in the cycle start_q is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_s) begin
            busy_q       <= 1'b1;
            word_count_q <= '0;
            start_q      <= 1'b1;
            mode_q       <= MODE_SPI;
            bits_q       <= EQIO_BITS;
            frame_q      <= {SRAM_CMD_EQIO, {(SHIFT_W-8){1'b0}}};
            state_q      <= ST_QUAD_EN;
          end
        end
        // A dropped load only takes effect once the frame in flight has closed.
        ST_QUAD_EN: begin
          if (sh_done) begin
            if (!load_s) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT_SCK;
            end
          end
        end
        ST_WAIT_SCK: begin
          if (!load_s) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (sck_rise) begin
            start_q <= 1'b1;
            mode_q  <= MODE_SQI;
            bits_q  <= WRITE_BITS;
            frame_q <= write_frame(word_count_q, rom_loader_data);
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (sh_done) begin
            word_count_q <= word_count_q + WORD_ADDR_WIDTH'(1);
            if (!load_s) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              ack_q   <= 1'b1;
              state_q <= ST_ACK_HI;
            end
          end
        end
        ST_ACK_HI: begin
          if (!load_s) begin
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!sck_s) begin
            ack_q   <= 1'b0;
            state_q <= ST_WAIT_SCK;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  qspi_write_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .start      (start_q),
    .mode_sqi   (mode_q == MODE_SQI),
    .bit_count  (bits_q),
    .shift_word (frame_q),
    .cs_n       (sh_cs_n),
    .sck        (sh_sck),
    .sio        (sh_sio),
    .done       (sh_done)
  );

  assign rom_cs_n       = sh_cs_n;
  assign rom_sck        = sh_sck;
  assign rom_sio_oe     = ~sh_cs_n;
  assign rom_sio0_o     = sh_sio[0];
  assign rom_sio1_o     = sh_sio[1];
  assign rom_sio2_o     = sh_sio[2];
  assign rom_sio3_o     = sh_sio[3];
  assign rom_loader_ack = ack_q;
  assign busy           = busy_q;
  assign words_loaded   = word_count_q;

endmodule
